// File: rtl/note_sequencer.sv
// note_sequencer
//   Plays a programmable 16-entry note table as a stream of tone frequencies
//   for a downstream DDS tone generator. Each entry holds a frequency in Hz and
//   a duration in ticks; a duration of 0 terminates the sequence. Every note is
//   followed by GAP_TICKS silent ticks. Playback either finishes (done pulse)
//   or restarts from entry 0 when loop is high.
//
// Ports
//   CLOCK_50  in   1   system clock
//   reset     in   1   asynchronous active-high reset
//   start     in   1   begin playback from entry 0 (ignored while playing)
//   stop      in   1   abort playback (wins over start)
//   loop      in   1   level; restart at entry 0 instead of finishing
//   wr_en     in   1   note-table write strobe
//   wr_addr   in   4   note-table write address
//   wr_freq   in  16   frequency (Hz) for the written entry
//   wr_dur    in   8   duration (ticks) for the written entry, 0 = end marker
//   freq      out 32   current tone frequency in Hz, 0 = silence
//   playing   out  1   high in PLAY or GAP
//   note_idx  out  4   entry currently playing or last played
//   done      out  1   one-cycle pulse when a non-looping sequence ends
module note_sequencer #(
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_freq,
  input  logic [7:0]  wr_dur,
  output logic [31:0] freq,
  output logic        playing,
  output logic [3:0]  note_idx,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam logic [19:0] TICK_LAST = 20'(TICK_DIV - 1);
  localparam logic [7:0]  GAP_INIT  = 8'(GAP_TICKS);

  // Note table (not cleared by reset)
  logic [15:0] tbl_freq_q [16];
  logic [7:0]  tbl_dur_q  [16];

  state_e      state_q, state_d;
  logic [19:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]  dur_cnt_q, dur_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0] freq_q, freq_d;
  logic        playing_q, playing_d;
  logic [3:0]  note_idx_q, note_idx_d;
  logic        done_q, done_d;

  logic        tick_s;
  logic [3:0]  next_idx_s;
  logic        has_next_s;
  logic        first_ok_s;
  logic        load_s;
  logic [3:0]  load_idx_s;
  logic        adv_s;
  logic        idle_s;

  assign tick_s     = (state_q != S_IDLE) && (tick_cnt_q == TICK_LAST);
  assign next_idx_s = note_idx_q + 4'd1;
  assign has_next_s = (note_idx_q != 4'd15) && (tbl_dur_q[next_idx_s] != 8'd0);
  assign first_ok_s = (tbl_dur_q[4'd0] != 8'd0);

  // Note table write port; accepted in every state
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) begin
      tbl_freq_q[wr_addr] <= wr_freq;
      tbl_dur_q[wr_addr]  <= wr_dur;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    dur_cnt_d  = dur_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    freq_d     = freq_q;
    note_idx_d = note_idx_q;
    done_d     = 1'b0;
    load_s     = 1'b0;
    load_idx_s = 4'd0;
    adv_s      = 1'b0;
    idle_s     = 1'b0;

    // Tick divider: parked at 0 in IDLE, free-running wrap otherwise
    if (state_q == S_IDLE) begin
      tick_cnt_d = 20'd0;
    end else if (tick_s) begin
      tick_cnt_d = 20'd0;
    end else begin
      tick_cnt_d = tick_cnt_q + 20'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (stop) begin
          idle_s = 1'b1;
        end else if (start) begin
          if (first_ok_s) begin
            load_s = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          idle_s = 1'b0;
        end
      end
      S_PLAY: begin
        if (stop) begin
          idle_s = 1'b1;
        end else if (tick_s) begin
          if (dur_cnt_q == 8'd1) begin
            if (GAP_TICKS != 0) begin
              state_d   = S_GAP;
              freq_d    = 32'd0;
              dur_cnt_d = 8'd0;
              gap_cnt_d = GAP_INIT;
            end else begin
              adv_s = 1'b1;
            end
          end else begin
            dur_cnt_d = dur_cnt_q - 8'd1;
          end
        end else begin
          adv_s = 1'b0;
        end
      end
      S_GAP: begin
        if (stop) begin
          idle_s = 1'b1;
        end else if (tick_s) begin
          if (gap_cnt_q == 8'd1) begin
            adv_s = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - 8'd1;
          end
        end else begin
          adv_s = 1'b0;
        end
      end
      default: begin
        idle_s = 1'b1;
      end
    endcase

    // Advance: next entry, wrap to entry 0 when looping, otherwise finish.
    // A looping table whose entry 0 is empty finishes like a non-looping one.
    if (adv_s) begin
      if (has_next_s) begin
        load_s     = 1'b1;
        load_idx_s = next_idx_s;
      end else if (loop && first_ok_s) begin
        load_s     = 1'b1;
        load_idx_s = 4'd0;
      end else begin
        idle_s = 1'b1;
        done_d = 1'b1;
      end
    end else begin
      load_idx_s = load_idx_s;
    end

    // Entry fields are sampled only here, so later writes do not disturb a note
    if (load_s) begin
      state_d    = S_PLAY;
      note_idx_d = load_idx_s;
      freq_d     = {16'h0000, tbl_freq_q[load_idx_s]};
      dur_cnt_d  = tbl_dur_q[load_idx_s];
      gap_cnt_d  = 8'd0;
    end else begin
      state_d = state_d;
    end

    if (idle_s) begin
      state_d    = S_IDLE;
      freq_d     = 32'd0;
      tick_cnt_d = 20'd0;
      dur_cnt_d  = 8'd0;
      gap_cnt_d  = 8'd0;
    end else begin
      state_d = state_d;
    end

    playing_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= 20'd0;
      dur_cnt_q  <= 8'd0;
      gap_cnt_q  <= 8'd0;
      freq_q     <= 32'd0;
      playing_q  <= 1'b0;
      note_idx_q <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      freq_q     <= freq_d;
      playing_q  <= playing_d;
      note_idx_q <= note_idx_d;
      done_q     <= done_d;
    end
  end

  assign freq     = freq_q;
  assign playing  = playing_q;
  assign note_idx = note_idx_q;
  assign done     = done_q;

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 500000, CLOCK_50 cycles per duration tick (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter GAP_TICKS, default 2, silent ticks inserted after every note; legal range 0..255.
REQ-003 CLOCK_50  input  1  system clock, 50 MHz; sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin playback from entry 0.
REQ-006 stop  input  1  single-cycle request to abort playback.
REQ-007 loop  input  1  level; when 1, playback restarts at entry 0 instead of finishing.
REQ-008 wr_en  input  1  note-table write strobe.
REQ-009 wr_addr  input  4  note-table write address.
REQ-010 wr_freq  input  16  note frequency in Hz for the written entry.
REQ-011 wr_dur  input  8  note duration in ticks; 0 marks end of sequence.
REQ-012 freq  output  32  tone frequency in Hz for the downstream DDS tone generator; 0 means silence.
REQ-013 playing  output  1  high while in PLAY or GAP state.
REQ-014 note_idx  output  4  index of the entry currently playing or last played.
REQ-015 done  output  1  one-cycle pulse when a non-looping sequence finishes.

Function
REQ-016 Note table SHALL be 16 entries x {freq[15:0], dur[7:0]}, written synchronously when wr_en=1, readable combinationally; writes are accepted in every state.
REQ-017 State machine SHALL have states IDLE, PLAY, GAP.
REQ-018 Tick counter SHALL be held at 0 in IDLE, cleared on every IDLE->PLAY transition, and in PLAY/GAP count 0..TICK_DIV-1 and wrap; tick is asserted in the cycle the counter equals TICK_DIV-1.
REQ-019 IDLE + start: if entry 0 dur=0, SHALL pulse done and remain IDLE; otherwise next cycle state=PLAY, note_idx=0, freq={16'h0,entry0.freq}, dur_cnt=entry0.dur.
REQ-020 PLAY: on tick, dur_cnt SHALL decrement; on tick with dur_cnt=1 the note ends.
REQ-021 Note end with GAP_TICKS>0: state=GAP, freq=0, gap_cnt=GAP_TICKS; on tick gap_cnt decrements; on tick with gap_cnt=1 advance (REQ-022).
REQ-022 Note end with GAP_TICKS=0 SHALL advance directly.
REQ-023 Advance: if note_idx!=15 and entry[note_idx+1].dur!=0, load that entry as in REQ-019 and enter PLAY.
REQ-024 Advance at end of sequence (note_idx=15, or next dur=0): loop=1 -> load entry 0 and enter PLAY (if entry 0 dur=0, treat as loop=0); loop=0 -> IDLE, freq=0, done=1 for one cycle; note_idx retains last value.
REQ-025 Entry fields SHALL be sampled only when loaded; writes to the entry currently playing do not change freq or dur_cnt.
REQ-026 stop in any state SHALL force IDLE, freq=0, playing=0 on the next edge, without a done pulse.
REQ-027 stop and start in the same cycle: stop wins; start ignored.
REQ-028 start while in PLAY or GAP SHALL be ignored.
REQ-029 freq, playing, note_idx, done SHALL be registered outputs.

Reset
REQ-030 reset=1 SHALL immediately force state=IDLE, freq=0, playing=0, note_idx=0, done=0, tick/dur/gap counters=0, regardless of clock.
REQ-031 Note table contents SHALL NOT be cleared by reset.
REQ-032 Reset asserted mid-note SHALL abort playback; after release the block waits in IDLE for start.

Verification (TICK_DIV=4, GAP_TICKS=1)
REQ-033 Table {0:(440,2),1:(880,1),2:dur 0}, start -> freq=440 for 8 cycles, 0 for 4, 880 for 4, 0 for 4, then done pulse, freq=0, note_idx=1.
REQ-034 Same table, loop=1 -> after entry 1 gap, freq returns to 440, no done pulse, playing stays 1.
REQ-035 stop during 880 note -> next edge freq=0, playing=0, done=0; subsequent start replays from 440.
REQ-036 Entry 0 dur=0, start -> done pulses one cycle, playing never asserts.
REQ-037 All 16 entries dur=1, loop=0 -> entries 0..15 play in order, done after entry 15's gap (note_idx=15).
REQ-038 Async reset mid-note, then write entry 0 during PLAY -> outputs zero immediately; table retained; written value used only on next load.
